// File: rtl/bsr_meta_loader.sv
// bsr_meta_loader: validates a DMA stream of BSR row_ptr/col_idx words,
// stores it in the metadata BRAM and serves it through a one-deep read port.
module bsr_meta_loader #(
   parameter int DEPTH        = 1024,
   parameter int AW           = 10,
   parameter int COL_IDX_BASE = 256,
   parameter int K_W          = 12,
   parameter int N_W          = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_start,
   input  logic           abort,
   input  logic [K_W-1:0] cfg_kt,
   input  logic [31:0]    cfg_nnz,
   input  logic [N_W-1:0] cfg_nt,
   input  logic [31:0]    s_data,
   input  logic           s_valid,
   output logic           s_ready,
   output logic           loaded,
   output logic           load_done,
   output logic           load_err,
   output logic [2:0]     err_code,
   input  logic [31:0]    meta_raddr,
   input  logic           meta_ren,
   output logic           meta_req_ready,
   output logic [31:0]    meta_rdata,
   output logic           meta_rvalid,
   input  logic           meta_ready
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_PTR,
      LOAD_COL,
      LOADED,
      ERR
   } state_t;

   localparam logic [32:0] BASE33  = 33'(COL_IDX_BASE);
   localparam logic [32:0] DEPTH33 = 33'(DEPTH);
   localparam logic [AW-1:0] BASE_A = AW'(COL_IDX_BASE);

   state_t         state;
   logic [K_W-1:0] kt;
   logic [31:0]    nnz;
   logic [N_W-1:0] nt;
   logic [31:0]    cnt;
   logic [31:0]    prev;

   logic           rd_valid;
   logic           rd_oor;
   logic [31:0]    rd_word;
   logic [31:0]    mem [DEPTH];

   logic           beat;
   logic           accept;
   logic [AW-1:0]  waddr;
   logic           last_ptr;
   logic           last_col;
   logic [2:0]     start_code;
   logic [2:0]     ptr_code;
   logic [2:0]     col_code;

   assign s_ready = (state == LOAD_PTR) || (state == LOAD_COL);
   assign beat    = s_valid && s_ready;

   assign meta_req_ready = loaded && !rd_valid;
   assign accept         = meta_ren && meta_req_ready;
   assign meta_rvalid    = rd_valid;
   assign meta_rdata     = (rd_valid && !rd_oor) ? rd_word : 32'd0;

   assign last_ptr = (cnt == 32'(kt));
   assign last_col = ((cnt + 32'd1) == nnz);

   // Write address: row_ptr at the bottom, col_idx from the region base.
   always_comb begin
      waddr = cnt[AW-1:0];
      if (state == LOAD_COL) waddr = BASE_A + cnt[AW-1:0];
   end

   // Configuration screening done at load_start, before any beat.
   always_comb begin
      start_code = 3'd0;
      if (cfg_kt == '0)
         start_code = 3'd1;
      else if (33'(cfg_kt) + 33'd1 > BASE33)
         start_code = 3'd2;
      else if (BASE33 + 33'(cfg_nnz) > DEPTH33)
         start_code = 3'd2;
   end

   // Per-beat validation of the row_ptr and col_idx words.
   always_comb begin
      ptr_code = 3'd0;
      col_code = 3'd0;
      if (cnt == 32'd0 && s_data != 32'd0)
         ptr_code = 3'd3;
      else if (s_data < prev)
         ptr_code = 3'd4;
      else if (last_ptr && s_data != nnz)
         ptr_code = 3'd5;
      if (s_data >= 32'(nt))
         col_code = 3'd6;
   end

   // Load FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         kt        <= '0;
         nnz       <= '0;
         nt        <= '0;
         cnt       <= '0;
         prev      <= '0;
         loaded    <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         err_code  <= 3'd0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         if (abort) begin
            state  <= IDLE;
            loaded <= 1'b0;
         end else begin
            case (state)
               IDLE, LOADED, ERR: begin
                  if (load_start) begin
                     kt       <= cfg_kt;
                     nnz      <= cfg_nnz;
                     nt       <= cfg_nt;
                     cnt      <= '0;
                     prev     <= '0;
                     loaded   <= 1'b0;
                     err_code <= 3'd0;
                     if (start_code != 3'd0) begin
                        state    <= ERR;
                        err_code <= start_code;
                        load_err <= 1'b1;
                     end else begin
                        state <= LOAD_PTR;
                     end
                  end
               end
               LOAD_PTR: begin
                  if (beat) begin
                     prev <= s_data;
                     cnt  <= cnt + 32'd1;
                     if (ptr_code != 3'd0) begin
                        state    <= ERR;
                        err_code <= ptr_code;
                        load_err <= 1'b1;
                     end else if (last_ptr) begin
                        cnt <= '0;
                        if (nnz == 32'd0) begin
                           state     <= LOADED;
                           loaded    <= 1'b1;
                           load_done <= 1'b1;
                        end else begin
                           state <= LOAD_COL;
                        end
                     end
                  end
               end
               LOAD_COL: begin
                  if (beat) begin
                     cnt <= cnt + 32'd1;
                     if (col_code != 3'd0) begin
                        state    <= ERR;
                        err_code <= col_code;
                        load_err <= 1'b1;
                     end else if (last_col) begin
                        state     <= LOADED;
                        loaded    <= 1'b1;
                        load_done <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Read slot: one response outstanding, held until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_oor   <= 1'b0;
      end else if (abort) begin
         rd_valid <= 1'b0;
      end else if (accept) begin
         rd_valid <= 1'b1;
         rd_oor   <= (meta_raddr >= 32'(DEPTH));
      end else if (rd_valid && meta_ready) begin
         rd_valid <= 1'b0;
      end
   end

   // Metadata BRAM: loader owns the write port, read side the read port.
   always_ff @(posedge clk) begin
      if (beat) mem[waddr] <= s_data;
      if (accept) rd_word <= mem[meta_raddr[AW-1:0]];
   end

endmodule

// File: tb/tb_bsr_meta_loader.sv
// tb_bsr_meta_loader: directed and randomized loads checked against a
// spec-level outcome predictor and a shadow copy of the metadata memory.
module tb_bsr_meta_loader;

   localparam int DEPTH = 1024;
   localparam int BASE  = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        abort = 1'b0;
   logic [11:0] cfg_kt = '0;
   logic [31:0] cfg_nnz = '0;
   logic [9:0]  cfg_nt = '0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        loaded;
   logic        load_done;
   logic        load_err;
   logic [2:0]  err_code;
   logic [31:0] meta_raddr = '0;
   logic        meta_ren = 1'b0;
   logic        meta_req_ready;
   logic [31:0] meta_rdata;
   logic        meta_rvalid;
   logic        meta_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] ptr_q [$];
   logic [31:0] col_q [$];
   logic [2:0]  exp_code = 3'd0;

   always #5 clk = ~clk;

   bsr_meta_loader dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_start     (load_start),
      .abort          (abort),
      .cfg_kt         (cfg_kt),
      .cfg_nnz        (cfg_nnz),
      .cfg_nt         (cfg_nt),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .loaded         (loaded),
      .load_done      (load_done),
      .load_err       (load_err),
      .err_code       (err_code),
      .meta_raddr     (meta_raddr),
      .meta_ren       (meta_ren),
      .meta_req_ready (meta_req_ready),
      .meta_rdata     (meta_rdata),
      .meta_rvalid    (meta_rvalid),
      .meta_ready     (meta_ready)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outcome of a load from the rules alone: error code and beats taken.
   task automatic predict(input int kt, input longint nnz, input int nt,
                          output int code, output int beats);
      logic [31:0] d;
      logic [31:0] prv;
      code  = 0;
      beats = 0;
      prv   = 0;
      if (kt == 0) begin
         code = 1;
         return;
      end
      if (kt + 1 > BASE || BASE + nnz > DEPTH) begin
         code = 2;
         return;
      end
      for (int i = 0; i <= kt; i++) begin
         d = ptr_q[i];
         beats++;
         if (i == 0 && d != 0) code = 3;
         else if (d < prv) code = 4;
         else if (i == kt && longint'(d) != nnz) code = 5;
         if (code != 0) return;
         prv = d;
      end
      for (int j = 0; j < nnz; j++) begin
         beats++;
         if (col_q[j] >= 32'(nt)) begin
            code = 6;
            return;
         end
      end
   endtask

   task automatic run_load(input int kt, input longint nnz, input int nt,
                           input int abort_after);
      int pcode;
      int pbeats;
      int beats;
      int dones;
      int errs;
      logic [31:0] strm [$];
      predict(kt, nnz, nt, pcode, pbeats);
      strm = {ptr_q, col_q};
      @(negedge clk);
      cfg_kt     = 12'(kt);
      cfg_nnz    = 32'(nnz);
      cfg_nt     = 10'(nt);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      beats = 0;
      dones = 0;
      errs  = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (load_done) dones++;
         if (load_err) errs++;
         if (dones + errs > 0) break;
         if (abort_after >= 0 && beats == abort_after) break;
         s_valid = ($urandom_range(0, 3) != 0) && (beats < strm.size());
         s_data  = s_valid ? strm[beats] : $urandom;
         if (s_valid && s_ready) beats++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      if (abort_after >= 0) begin
         check("abort_reached", beats, abort_after);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         exp_code = 3'd0;
         check("abort_s_ready", s_ready, 0);
         check("abort_loaded", loaded, 0);
         check("abort_err_code", err_code, exp_code);
         @(negedge clk);
         check("abort_idle", s_ready | loaded | load_done | load_err, 0);
         return;
      end
      check("done_pulse", dones, (pcode == 0) ? 1 : 0);
      check("err_pulse", errs, (pcode != 0) ? 1 : 0);
      check("beats", beats, pbeats);
      @(negedge clk);
      check("s_ready_after", s_ready, 0);
      check("loaded", loaded, (pcode == 0) ? 1 : 0);
      check("err_code", err_code, pcode);
      check("pulse_width", load_done | load_err, 0);
      exp_code = 3'(pcode);
      if (pcode == 0) begin
         for (int i = 0; i <= kt; i++) mem_m[i] = ptr_q[i];
         for (int j = 0; j < nnz; j++) mem_m[BASE + j] = col_q[j];
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold);
      logic [31:0] exp;
      exp = (addr >= DEPTH) ? 32'd0 : mem_m[addr[9:0]];
      @(negedge clk);
      meta_raddr = addr;
      meta_ren   = 1'b1;
      for (int k = 0; k < 20 && !meta_req_ready; k++) @(negedge clk);
      check("req_ready", meta_req_ready, 1);
      @(negedge clk);
      meta_ren = 1'($urandom_range(0, 1));
      check("rvalid", meta_rvalid, 1);
      check("rdata", meta_rdata, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("rvalid_hold", meta_rvalid, 1);
         check("rdata_hold", meta_rdata, exp);
         check("req_blocked", meta_req_ready, 0);
      end
      meta_ready = 1'b1;
      @(negedge clk);
      meta_ready = 1'b0;
      meta_ren   = 1'b0;
      check("rvalid_clear", meta_rvalid, 0);
      check("req_ready_back", meta_req_ready, 1);
   endtask

   task automatic gen_random();
      int kt;
      int nt;
      longint nnz;
      int mode;
      logic [31:0] p;
      mode = $urandom_range(0, 9);
      kt   = $urandom_range(1, 6);
      nt   = $urandom_range(1, 8);
      ptr_q.delete();
      col_q.delete();
      p = 0;
      ptr_q.push_back(0);
      for (int i = 1; i <= kt; i++) begin
         p += $urandom_range(0, 3);
         ptr_q.push_back(p);
      end
      nnz = p;
      for (int j = 0; j < nnz; j++) col_q.push_back($urandom_range(0, nt - 1));
      case (mode)
         5: ptr_q[$urandom_range(0, kt)] = $urandom_range(0, 15);
         6: ptr_q[0] = 1;
         7: begin
            nnz++;
            col_q.push_back(0);
         end
         8: if (nnz > 0) col_q[$urandom_range(0, int'(nnz) - 1)] = nt + $urandom_range(0, 3);
         9: kt = $urandom_range(0, 1) ? 0 : $urandom_range(255, 400);
         default: ;
      endcase
      run_load(kt, nnz, nt, -1);
      if (exp_code == 0 && loaded) begin
         do_read($urandom_range(0, kt), $urandom_range(0, 3));
         if (nnz > 0) do_read(BASE + $urandom_range(0, int'(nnz) - 1), $urandom_range(0, 3));
         do_read(DEPTH + $urandom_range(0, 5000), 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_loaded", loaded, 0);
      check("rst_pulses", {load_done, load_err}, 0);
      check("rst_err_code", err_code, 0);
      check("rst_req_ready", meta_req_ready, 0);
      check("rst_rvalid", meta_rvalid, 0);
      check("rst_rdata", meta_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      ptr_q = '{0, 1, 3};
      col_q = '{2, 0, 3};
      run_load(2, 3, 4, -1);
      do_read(1, 0);
      do_read(257, 1);
      do_read(258, 0);
      do_read(0, 5);
      do_read(2000, 0);

      ptr_q = '{0, 0, 0, 0};
      col_q.delete();
      run_load(3, 0, 4, -1);

      ptr_q = '{0, 2, 1};
      col_q = '{0};
      run_load(2, 1, 4, -1);

      ptr_q = '{0, 1};
      col_q = '{5};
      run_load(1, 1, 4, -1);

      ptr_q.delete();
      col_q.delete();
      run_load(300, 0, 4, -1);
      ptr_q = '{0, 800};
      run_load(1, 800, 4, -1);

      ptr_q.delete();
      for (int i = 0; i <= 255; i++) ptr_q.push_back(0);
      run_load(255, 0, 4, -1);
      do_read(255, 0);

      ptr_q = '{0, 2};
      col_q = '{1, 3};
      run_load(1, 2, 4, -1);
      @(negedge clk);
      meta_raddr = 257;
      meta_ren   = 1'b1;
      @(negedge clk);
      meta_ren = 1'b0;
      check("pend_rvalid", meta_rvalid, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_rd_rvalid", meta_rvalid, 0);
      check("abort_rd_loaded", loaded, 0);
      check("abort_rd_s_ready", s_ready, 0);
      check("abort_rd_req", meta_req_ready, 0);
      check("abort_rd_code", err_code, exp_code);

      ptr_q = '{0, 2, 4};
      col_q = '{1, 1, 1, 1};
      run_load(2, 4, 4, 5);

      ptr_q = '{0, 1, 2};
      col_q = '{3, 2};
      run_load(2, 2, 4, -1);
      do_read(2, 0);
      do_read(256, 2);

      for (int r = 0; r < 40; r++) gen_random();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
